// File: rtl/ram_bus_master.sv
// ram_bus_master: bridges one core request at a time onto a tristate RAM bus.
// Macro RAM_BUS_MASTER_RMW_EN enables byte-strobe read-modify-write.
module ram_bus_master #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_adr,
   inout  wire  [DATA_WIDTH-1:0]   mem_data
);

   localparam int NB = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RD_ADDR,
      RD_DATA,
`ifdef RAM_BUS_MASTER_RMW_EN
      RMW_ADDR,
      RMW_DATA,
      RMW_WRITE,
`endif
      RESP
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] wdata_q;

`ifdef RAM_BUS_MASTER_RMW_EN
   logic [NB-1:0]         wstrb_q;
   logic [DATA_WIDTH-1:0] merged;
   logic                  wstrb_full;
   logic                  wstrb_zero;

   assign wstrb_full = &req_wstrb;
   assign wstrb_zero = ~|req_wstrb;

   // Overlay enabled write bytes onto the word read back from RAM.
   always_comb begin
      merged = mem_data;
      for (int i = 0; i < NB; i++) begin
         if (wstrb_q[i]) begin
            merged[8*i +: 8] = wdata_q[8*i +: 8];
         end
      end
   end
`else
   logic unused_wstrb;
   assign unused_wstrb = ^req_wstrb;
`endif

   // The bus is driven only from the registered write state.
   assign mem_data = mem_we ? wdata_q : {DATA_WIDTH{1'bz}};

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_we    = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = rst_n;
            if (req_valid) begin
               if (!req_we) begin
                  state_nxt = RD_ADDR;
               end else begin
`ifdef RAM_BUS_MASTER_RMW_EN
                  if (wstrb_zero) begin
                     state_nxt = RESP;
                  end else if (wstrb_full) begin
                     state_nxt = WRITE;
                  end else begin
                     state_nxt = RMW_ADDR;
                  end
`else
                  state_nxt = WRITE;
`endif
               end
            end
         end
         WRITE: begin
            mem_we    = 1'b1;
            state_nxt = RESP;
         end
         RD_ADDR:   state_nxt = RD_DATA;
         RD_DATA:   state_nxt = RESP;
`ifdef RAM_BUS_MASTER_RMW_EN
         RMW_ADDR:  state_nxt = RMW_DATA;
         RMW_DATA:  state_nxt = RMW_WRITE;
         RMW_WRITE: begin
            mem_we    = 1'b1;
            state_nxt = RESP;
         end
`endif
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default:   state_nxt = IDLE;
      endcase
   end

   // Request latch, RAM address and read data capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_adr   <= '0;
         rsp_rdata <= '0;
         wdata_q   <= '0;
`ifdef RAM_BUS_MASTER_RMW_EN
         wstrb_q   <= '0;
`endif
      end else begin
         if (state == IDLE && req_valid) begin
            wdata_q <= req_wdata;
`ifdef RAM_BUS_MASTER_RMW_EN
            wstrb_q <= req_wstrb;
            if (!(req_we && wstrb_zero)) begin
               mem_adr <= req_addr;
            end
`else
            mem_adr <= req_addr;
`endif
         end
         if (state == RD_DATA) begin
            rsp_rdata <= mem_data;
         end
`ifdef RAM_BUS_MASTER_RMW_EN
         if (state == RMW_DATA) begin
            wdata_q <= merged;
         end
`endif
      end
   end

endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master: scoreboard bench for ram_bus_master with a RAM model.
// Expectations follow RAM_BUS_MASTER_RMW_EN when it is defined.
module tb_ram_bus_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wstrb = '0;
   logic        rsp_ready = 1'b0;
   logic        req_ready;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        mem_we;
   logic [15:0] mem_adr;
   wire  [63:0] mem_data;

   int checks = 0;
   int errors = 0;

   logic [63:0] ram [256];
   logic [63:0] ram_q;
   logic        ram_init = 1'b0;
   logic [63:0] model [256];
   logic [63:0] last_rd = '0;
   logic [63:0] exp_bus = '0;
   logic        bus_chk = 1'b0;
   int          we_cycles = 0;

   typedef struct {
      logic [63:0] rdata;
      int          lat;
   } exp_t;
   exp_t sb [$];

   always #5 clk = ~clk;

   ram_bus_master dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .mem_we    (mem_we),
      .mem_adr   (mem_adr),
      .mem_data  (mem_data)
   );

   function automatic logic [63:0] pat(int i);
      return 64'hA5A5_0000_0000_0000 | (64'(i) * 64'h0001_0001);
   endfunction

   // Synchronous RAM: registered read, drives the bus when not written.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= pat(i);
      end else if (mem_we) begin
         ram[mem_adr[7:0]] <= mem_data;
      end
      ram_q <= ram[mem_adr[7:0]];
   end

   assign mem_data = mem_we ? {64{1'bz}} : ram_q;

   // Per-cycle bus monitor.
   always @(negedge clk) begin
      if (mem_we) we_cycles++;
      if (bus_chk) begin
         checks++;
         if (mem_we) begin
            if (mem_data !== exp_bus) begin
               errors++;
               $display("FAIL bus_wr got %h want %h", mem_data, exp_bus);
            end
         end else if (mem_data !== ram_q) begin
            errors++;
            $display("FAIL bus_rd got %h want %h", mem_data, ram_q);
         end
      end
   end

   task automatic do_req(input logic we, input logic [15:0] a,
                         input logic [63:0] d, input logic [7:0] s,
                         input int hold);
      exp_t        e;
      exp_t        g;
      logic [63:0] nw;
      logic [63:0] hv;
      int          k;
      int          w0;
      int          wexp;
      nw = model[a[7:0]];
      if (!we) begin
         e.lat   = 3;
         e.rdata = nw;
         last_rd = nw;
      end else begin
`ifdef RAM_BUS_MASTER_RMW_EN
         e.lat = (s == 8'h00) ? 1 : (s == 8'hFF) ? 2 : 4;
         for (int i = 0; i < 8; i++) begin
            if (s[i]) nw[8*i +: 8] = d[8*i +: 8];
         end
`else
         e.lat = 2;
         nw    = d;
`endif
         e.rdata = last_rd;
         exp_bus = nw;
      end
      wexp = (we && e.lat != 1) ? 1 : 0;
      w0 = we_cycles;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_wstrb = s;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 20) begin
         errors++;
         $display("FAIL accept got ready=%b want 1", req_ready);
      end
      @(posedge clk);
      sb.push_back(e);
      if (we) model[a[7:0]] = nw;
      #1;
      req_we    = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = {$urandom, $urandom};
      req_wstrb = 8'($urandom);
      @(negedge clk);
      k = 1;
      while (!rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      g = sb.pop_front();
      checks++;
      if (k !== g.lat) begin
         errors++;
         $display("FAIL latency got %0d want %0d", k, g.lat);
      end
      checks++;
      if (rsp_rdata !== g.rdata) begin
         errors++;
         $display("FAIL rdata got %h want %h", rsp_rdata, g.rdata);
      end
      hv = rsp_rdata;
      repeat (hold) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== hv ||
             req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold got v=%b d=%h r=%b want 1 %h 0",
                     rsp_valid, rsp_rdata, req_ready, hv);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checks++;
      if (we_cycles - w0 !== wexp) begin
         errors++;
         $display("FAIL we_count got %0d want %0d", we_cycles - w0, wexp);
      end
      if (we) begin
         checks++;
         if (ram[a[7:0]] !== model[a[7:0]]) begin
            errors++;
            $display("FAIL ram got %h want %h", ram[a[7:0]], model[a[7:0]]);
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 256; i++) model[i] = pat(i);
      rst_n = 1'b0;
      ram_init = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      ram_init = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || mem_we !== 1'b0 || mem_adr !== 16'h0 ||
          rsp_valid !== 1'b0 || rsp_rdata !== 64'h0) begin
         errors++;
         $display("FAIL reset got r=%b w=%b a=%h v=%b d=%h want 0",
                  req_ready, mem_we, mem_adr, rsp_valid, rsp_rdata);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", req_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_read();
      do_req(1'b1, 16'h0010, 64'h1122334455667788, 8'hFF, 0);
      do_req(1'b0, 16'h0010, 64'h0, 8'h00, 0);
      checks++;
      if (rsp_rdata !== 64'h1122334455667788) begin
         errors++;
         $display("FAIL readback got %h want 1122334455667788", rsp_rdata);
      end
      do_req(1'b0, 16'h0003, 64'h0, 8'h00, 0);
   endtask

   task automatic test_partial_write();
      logic [63:0] want;
`ifdef RAM_BUS_MASTER_RMW_EN
      want = 64'hFFFFFFFF00000000;
`else
      want = 64'h0;
`endif
      do_req(1'b1, 16'h0020, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0);
      do_req(1'b1, 16'h0020, 64'h0, 8'h0F, 0);
      do_req(1'b0, 16'h0020, 64'h0, 8'h00, 0);
      checks++;
      if (rsp_rdata !== want) begin
         errors++;
         $display("FAIL rmw got %h want %h", rsp_rdata, want);
      end
   endtask

   task automatic test_zero_strobe();
      do_req(1'b1, 16'h0030, 64'hDEADBEEF01234567, 8'h00, 0);
      do_req(1'b0, 16'h0030, 64'h0, 8'h00, 0);
   endtask

   task automatic test_backpressure();
      do_req(1'b0, 16'h0010, 64'h0, 8'h00, 5);
      do_req(1'b1, 16'h0011, 64'h0F0E0D0C0B0A0908, 8'hFF, 5);
   endtask

   task automatic test_stream();
      logic        we;
      logic [15:0] a;
      logic [7:0]  s;
      int          r;
      bus_chk = 1'b1;
      for (int n = 0; n < 20; n++) begin
         we = 1'($urandom_range(0, 1));
         a  = 16'($urandom_range(0, 15));
         r  = $urandom_range(0, 3);
         s  = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
         do_req(we, a, {$urandom, $urandom}, s, $urandom_range(0, 2));
      end
      bus_chk = 1'b0;
   endtask

   task automatic test_reset_rd_data();
      int k;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'h0010;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 ||
          req_ready !== 1'b0 || mem_adr !== 16'h0) begin
         errors++;
         $display("FAIL rst_rd got v=%b d=%h r=%b a=%h want 0",
                  rsp_valid, rsp_rdata, req_ready, mem_adr);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_rd_rel got r=%b v=%b want 1 0",
                  req_ready, rsp_valid);
      end
      last_rd = '0;
      sb.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_write();
      int k;
      int w0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'h0040;
      req_wdata = 64'h0BADF00DCAFEBEEF;
      req_wstrb = 8'hFF;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      w0 = we_cycles;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      model[8'h40] = 64'h0BADF00DCAFEBEEF;
      checks++;
      if (ram[8'h40] !== model[8'h40] || we_cycles - w0 !== 1 ||
          rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_wr got m=%h w=%0d v=%b want %h 1 0",
                  ram[8'h40], we_cycles - w0, rsp_valid, model[8'h40]);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_wr_rel got %b want 1", req_ready);
      end
      last_rd = '0;
      @(posedge clk);
      #1;
      do_req(1'b0, 16'h0040, 64'h0, 8'h00, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_partial_write();
      test_zero_strobe();
      test_backpressure();
      test_stream();
      test_reset_rd_data();
      test_reset_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
